// File: rtl/video_pkg.sv
// video_pkg: shared video geometry constants and helpers
package video_pkg;
    localparam int X_SIZE_DEFAULT  = 640;
    localparam int Y_SIZE_DEFAULT  = 480;
    localparam int BYTES_PER_PIXEL = 3;
    localparam int WORDS_PER_LINE  = BYTES_PER_PIXEL * X_SIZE_DEFAULT / 4;
    function automatic int words_per_line(input int x_size);
        return BYTES_PER_PIXEL * x_size / 4;
    endfunction
endpackage

// File: rtl/video_unpacker_if.sv
// video_unpacker_if: packed-word AXI-Stream input and unpacked pixel output bundles
interface axis_video_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;
    modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

interface pixel_if;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [15:0] x;
    logic [15:0] y;
    logic        sof;
    logic        eol;
    logic        valid;
    logic        ready;
    modport master (output r, g, b, x, y, sof, eol, valid, input ready);
    modport slave  (input r, g, b, x, y, sof, eol, valid, output ready);
endinterface

// File: rtl/pixel_byte_buffer.sv
// pixel_byte_buffer: 9-byte shift register that appends 4-byte words and pops 3-byte pixels
module pixel_byte_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_push,
    input  logic [31:0] i_word,
    input  logic        i_pop,
    output logic [7:0]  o_b,
    output logic [7:0]  o_g,
    output logic [7:0]  o_r,
    output logic        o_valid,
    output logic        o_ready
);
    logic [71:0] r_data;
    logic [71:0] w_data;
    logic [3:0]  r_cnt;
    logic [3:0]  w_keep;
    logic [3:0]  w_cnt;
    logic        r_valid;
    logic        r_ready;
    // Drop popped or flushed bytes, then place the new word just above the survivors;
    // bytes above the count are always zero so the append can simply be OR-ed in
    always_comb begin
        w_keep = i_flush ? 4'd0 : (i_pop ? r_cnt - 4'd3 : r_cnt);
        w_data = i_flush ? 72'd0 : (i_pop ? r_data >> 24 : r_data);
        w_data = i_push ? (w_data | (72'(i_word) << {w_keep, 3'b000})) : w_data;
        w_cnt  = i_push ? w_keep + 4'd4 : w_keep;
    end
    // Buffer state; valid and ready are registered from the next occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_data  <= w_data;
            r_cnt   <= w_cnt;
            r_valid <= w_cnt >= 4'd3;
            r_ready <= w_cnt <= 4'd5;
        end
    end
    assign o_b     = r_data[7:0];
    assign o_g     = r_data[15:8];
    assign o_r     = r_data[23:16];
    assign o_valid = r_valid;
    assign o_ready = r_ready;
endmodule

// File: rtl/video_unpacker.sv
// video_unpacker: unpacks b,g,r pixels from a 32-bit AXI-Stream and tracks frame position
module video_unpacker
    import video_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEFAULT,
    parameter int Y_SIZE = Y_SIZE_DEFAULT
) (
    input  logic         aclk,
    input  logic         areset,
    axis_video_if.slave  in_stream,
    pixel_if.master      pix,
    output logic         err_sof,
    output logic         err_eol,
    output logic [15:0]  frame_cnt
);
    localparam int          WPL       = words_per_line(X_SIZE);
    localparam logic [15:0] LAST_WORD = 16'(WPL - 1);
    localparam logic [15:0] LAST_X    = 16'(X_SIZE - 1);
    localparam logic [15:0] LAST_Y    = 16'(Y_SIZE - 1);

    logic [15:0] r_in_word;
    logic [15:0] r_in_line;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_frame;
    logic        r_err_sof;
    logic        r_err_eol;
    logic        w_accept;
    logic        w_xfer;
    logic        w_first;
    logic        w_last;
    logic        w_resync;

    assign w_accept = in_stream.tvalid & in_stream.tready;
    assign w_xfer   = pix.valid & pix.ready;
    assign w_first  = (r_in_word == '0) && (r_in_line == '0);
    assign w_last   = r_in_word == LAST_WORD;
    assign w_resync = w_accept & in_stream.tuser & ~w_first;

    pixel_byte_buffer u_buf (
        .clk     (aclk),
        .rst     (areset),
        .i_flush (w_resync),
        .i_push  (w_accept),
        .i_word  (in_stream.tdata),
        .i_pop   (w_xfer),
        .o_b     (pix.b),
        .o_g     (pix.g),
        .o_r     (pix.r),
        .o_valid (pix.valid),
        .o_ready (in_stream.tready)
    );

    // Input word position; an unexpected start-of-frame word becomes word 0 of a new frame
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_in_word <= '0;
            r_in_line <= '0;
        end else if (w_accept) begin
            if (w_resync) begin
                r_in_word <= 16'd1;
                r_in_line <= '0;
            end else if (w_last) begin
                r_in_word <= '0;
                r_in_line <= (r_in_line == LAST_Y) ? '0 : r_in_line + 16'd1;
            end else begin
                r_in_word <= r_in_word + 16'd1;
            end
        end
    end

    // Output pixel position and completed-frame count; resync snaps back to frame start
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_frame <= '0;
        end else begin
            if (w_xfer && r_x == LAST_X && r_y == LAST_Y)
                r_frame <= r_frame + 16'd1;
            if (w_resync) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_xfer) begin
                r_x <= (r_x == LAST_X) ? '0 : r_x + 16'd1;
                r_y <= (r_x != LAST_X) ? r_y : ((r_y == LAST_Y) ? '0 : r_y + 16'd1);
            end
        end
    end

    // Framing error pulses, one cycle after the offending accept
    always_ff @(posedge aclk) begin
        r_err_sof <= !areset && w_accept && (in_stream.tuser != w_first);
        r_err_eol <= !areset && w_accept && (in_stream.tlast != w_last);
    end

    assign pix.x     = r_x;
    assign pix.y     = r_y;
    assign pix.sof   = (r_x == '0) && (r_y == '0);
    assign pix.eol   = r_x == LAST_X;
    assign err_sof   = r_err_sof;
    assign err_eol   = r_err_eol;
    assign frame_cnt = r_frame;
endmodule
